// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, transmitter states, line levels and parity helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    GUARD  = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Even parity: XOR over data plus this bit is zero.
  function automatic logic even_par(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic RST_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Free-running bit counter, held at zero while cleared.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear || (cnt_r == TERM)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_done = (cnt_r == TERM);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, 8 data bits LSB-first, even parity, stop bit(s), then an idle-high guard.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 1,
  parameter int STOP_BITS     = 1,
  parameter int MIN_IDLE_BITS = 2
) (
  input  logic                 CLOCK_125_p,
  input  logic                 RST_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 Tx,
  output logic                 busy
);

  localparam int GW = (MIN_IDLE_BITS < 2) ? 1 : $clog2(MIN_IDLE_BITS + 1);

  state_e               state_r;
  logic [GW-1:0]        guard_cnt_r;
  logic [2:0]           bit_idx_r;
  logic                 stop_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_r;
  logic                 tx_r;
  logic                 tx_ready_r;
  logic                 busy_r;
  logic                 bit_done_s;
  logic                 clear_s;

  assign clear_s = (state_r == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (CLOCK_125_p),
    .RST_n    (RST_n),
    .clear    (clear_s),
    .bit_done (bit_done_s)
  );

  // Frame FSM; Tx/tx_ready/busy are loaded with the value of the state being entered.
  always_ff @(posedge CLOCK_125_p or negedge RST_n) begin
    if (!RST_n) begin
      state_r     <= GUARD;
      guard_cnt_r <= GW'(MIN_IDLE_BITS);
      bit_idx_r   <= 3'd0;
      stop_cnt_r  <= 1'b0;
      shift_r     <= {DATA_BITS{1'b0}};
      parity_r    <= 1'b0;
      tx_r        <= LINE_IDLE;
      tx_ready_r  <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        GUARD: begin
          if ((MIN_IDLE_BITS == 0) || (bit_done_s && (guard_cnt_r == GW'(1)))) begin
            state_r    <= IDLE;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else if (bit_done_s) begin
            guard_cnt_r <= guard_cnt_r - GW'(1);
          end
          tx_r <= LINE_IDLE;
        end
        IDLE: begin
          if (tx_valid && tx_ready_r) begin
            shift_r    <= tx_data;
            parity_r   <= even_par(tx_data);
            state_r    <= START;
            tx_r       <= START_LVL;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (bit_done_s) begin
            state_r   <= DATA;
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
              state_r <= PARITY;
              tx_r    <= parity_r;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              tx_r      <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bit_done_s) begin
            state_r    <= STOP;
            stop_cnt_r <= 1'b0;
            tx_r       <= LINE_IDLE;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
              if (MIN_IDLE_BITS == 0) begin
                state_r    <= IDLE;
                tx_ready_r <= 1'b1;
                busy_r     <= 1'b0;
              end else begin
                state_r     <= GUARD;
                guard_cnt_r <= GW'(MIN_IDLE_BITS);
              end
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= GUARD;
          guard_cnt_r <= GW'(MIN_IDLE_BITS);
          tx_r        <= LINE_IDLE;
          tx_ready_r  <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  assign Tx       = tx_r;
  assign tx_ready = tx_ready_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: default instance plus a CLKS_PER_BIT=4 instance, with a frame-decoding scoreboard.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       v1 = 1'b0;
  logic       r1, tx1, b1;
  logic [7:0] d4 = 8'h00;
  logic       v4 = 1'b0;
  logic       r4, tx4, b4;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int mon_frames = 0;

  uart_tx_framer dut (
    .CLOCK_125_p(clk), .RST_n(rst_n), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .Tx(tx1), .busy(b1)
  );

  uart_tx_framer #(.CLKS_PER_BIT(4)) dut4 (
    .CLOCK_125_p(clk), .RST_n(rst_n), .tx_data(d4), .tx_valid(v4),
    .tx_ready(r4), .Tx(tx4), .busy(b4)
  );

  always #4 clk = ~clk;

  // Receive-side model: decode 11-bit frames from Tx at one sample per clock.
  logic        mon_prev = 1'b1;
  logic        mon_on = 1'b0;
  int          mon_bit = 0;
  logic [10:0] mon_frame;
  logic [7:0]  mon_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on   = 1'b0;
      mon_prev = 1'b1;
    end else if (!mon_on) begin
      if (mon_prev && (tx1 == 1'b0)) begin
        mon_on       = 1'b1;
        mon_frame[0] = tx1;
        mon_bit      = 1;
      end
      mon_prev = tx1;
    end else begin
      mon_frame[mon_bit] = tx1;
      mon_bit++;
      if (mon_bit == 11) begin
        mon_on   = 1'b0;
        mon_prev = tx1;
        mon_frames++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_frame got=%h exp=none", mon_frame[8:1]);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_frame[8:1] !== mon_exp) begin
            errors++;
            $display("FAIL sb_data got=%h exp=%h", mon_frame[8:1], mon_exp);
          end
          checks++;
          if ((^mon_frame[8:1]) !== mon_frame[9]) begin
            errors++;
            $display("FAIL sb_parity got=%b exp=%b", mon_frame[9], ^mon_frame[8:1]);
          end
          checks++;
          if (mon_frame[10] !== 1'b1) begin
            errors++;
            $display("FAIL sb_stop got=%b exp=1", mon_frame[10]);
          end
        end
      end
    end
  end

  // Wait (bounded) for ready, present a byte, return #1 after the accept edge.
  task automatic send1(input logic [7:0] d, input logic keep_valid);
    int n = 0;
    while ((r1 !== 1'b1) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (r1 !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout got=%b exp=1", r1);
    end
    d1 = d;
    v1 = 1'b1;
    exp_q.push_back(d);
    @(posedge clk); #1;
    if (!keep_valid) v1 = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while ((mon_frames < target) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (mon_frames < target) begin
      errors++;
      $display("FAIL frame_timeout got=%0d exp=%0d", mon_frames, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx1, r1, b1, tx4, r4, b4} !== 6'b101_101) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=101101", {tx1, r1, b1, tx4, r4, b4});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r1 !== (i >= 2) || tx1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_guard_dflt clk=%0d got=r%b tx%b exp=r%b tx1", i, r1, tx1, (i >= 2));
      end
      checks++;
      if (r4 !== (i >= 8) || tx4 !== 1'b1) begin
        errors++;
        $display("FAIL reset_guard_cpb4 clk=%0d got=r%b tx%b exp=r%b tx1", i, r4, tx4, (i >= 8));
      end
    end
  endtask

  task automatic test_a5();
    logic [12:0] seq;
    seq = 13'b111_0_10100101_0;
    send1(8'hA5, 1'b0);
    for (int c = 0; c < 13; c++) begin
      checks++;
      if (tx1 !== seq[c] || b1 !== 1'b1 || r1 !== 1'b0) begin
        errors++;
        $display("FAIL a5_frame clk=%0d got=tx%b busy%b rdy%b exp=tx%b busy1 rdy0", c, tx1, b1, r1, seq[c]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (b1 !== 1'b0 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL a5_idle got=busy%b rdy%b exp=busy0 rdy1", b1, r1);
    end
  endtask

  task automatic test_cpb4();
    logic [10:0] seq;
    seq = 11'b1_1_00000111_0;
    checks++;
    if (r4 !== 1'b1) begin
      errors++;
      $display("FAIL cpb4_ready got=%b exp=1", r4);
    end
    d4 = 8'h07;
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    d4 = 8'hFF;
    for (int c = 0; c <= 52; c++) begin
      logic exp_tx;
      exp_tx = (c < 44) ? seq[c / 4] : 1'b1;
      checks++;
      if (tx4 !== exp_tx || r4 !== (c == 52)) begin
        errors++;
        $display("FAIL cpb4_frame clk=%0d got=tx%b rdy%b exp=tx%b rdy%b", c, tx4, r4, exp_tx, (c == 52));
      end
      if (c < 52) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = mon_frames;
    send1(8'h3C, 1'b1);
    d1 = 8'hC3;
    exp_q.push_back(8'hC3);
    for (int c = 0; c <= 14; c++) begin
      logic exp_tx;
      exp_tx = (c == 0 || c == 14) ? 1'b0 : (c == 9) ? 1'b0 : (c >= 10) ? 1'b1 : (c >= 1 && c <= 8) ? ((8'h3C >> (c - 1)) & 8'h01) != 8'h00 : 1'b1;
      checks++;
      if (tx1 !== exp_tx || r1 !== (c == 13)) begin
        errors++;
        $display("FAIL b2b_timing clk=%0d got=tx%b rdy%b exp=tx%b rdy%b", c, tx1, r1, exp_tx, (c == 13));
      end
      @(posedge clk); #1;
      if (c == 13) v1 = 1'b0;
    end
    wait_frames(base + 2);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    send1(8'h00, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (tx1 !== 1'b0 || b1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bit4 got=tx%b busy%b exp=tx0 busy1", tx1, b1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx1 !== 1'b1 || r1 !== 1'b0 || b1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async got=tx%b rdy%b busy%b exp=tx1 rdy0 busy1", tx1, r1, b1);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r1 !== (i == 2) || tx1 !== 1'b1) begin
        errors++;
        $display("FAIL midrst_guard clk=%0d got=rdy%b tx%b exp=rdy%b tx1", i, r1, tx1, (i == 2));
      end
    end
    base = mon_frames;
    send1(8'h55, 1'b0);
    wait_frames(base + 1);
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    int base;
    bytes = '{8'h00, 8'hFF, 8'h81, 8'h3C};
    base = mon_frames;
    for (int i = 0; i < 4; i++) send1(bytes[i], 1'b0);
    wait_frames(base + 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL loopback_pending got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_cpb4();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- UART transmit stage that directly feeds the UART receive stage's Rx pin.
- Accepts one byte per valid/ready handshake and serialises it LSB-first as a frame: start bit, 8 data bits, even-parity bit, then stop bit(s).
- Enforces an idle-high guard between frames. The receiver needs Rx high for at least 2 clocks before a start edge.
- Bit timing comes from an internal baud counter. The default of 1 clock per bit matches the receiver's per-clock sampling.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit (must be ≥1).
- STOP_BITS, 1, number of stop bits (1 or 2).
- MIN_IDLE_BITS, 2, extra idle-high bit-times after the stop bits and after reset.

Ports:
- CLOCK_125_p  input  1  system clock; all logic is on its rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept a byte (IDLE state only).
- Tx  output  1  serial line; registered, idle high.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Clock and reset: one clock, CLOCK_125_p; reset is RST_n, asynchronous assert, active-low, with synchronous deassert.
- While RST_n=0:
  - Tx=1, tx_ready=0, busy=1.
  - State = GUARD, guard counter loaded with MIN_IDLE_BITS.
  - Baud counter = 0.
- States: GUARD → IDLE → START → DATA → PARITY → STOP → GUARD.
- Bit timing: the baud counter counts 0..CLKS_PER_BIT-1; bit_done is asserted at the terminal count. Every state except IDLE holds its Tx value for exactly CLKS_PER_BIT clocks.
- GUARD:
  - Tx=1 for MIN_IDLE_BITS bit-times, then go to IDLE.
  - If MIN_IDLE_BITS=0, GUARD lasts 0 cycles and STOP goes straight to IDLE.
- IDLE:
  - Tx=1, tx_ready=1, busy=0.
  - On the rising edge where tx_valid & tx_ready: capture tx_data into the shift register and compute parity = ^tx_data. Go to START; the baud counter resets.
- START: Tx=0 for one bit-time.
- DATA:
  - Tx = shift_reg[0]; shift right on each bit_done.
  - 3-bit index counts 0..7; after bit 7 go to PARITY.
- PARITY: Tx = captured parity for one bit-time. XOR over data plus parity is 0, which the receiver checks as (^data)==parity_bit.
- STOP: Tx=1 for STOP_BITS bit-times, then go to GUARD.
- Latency: handshake at edge k → Tx=0 from edge k+1. Frame = (1+8+1+STOP_BITS)·CLKS_PER_BIT clocks.
- Throughput: with valid held high, start-to-start = (10+STOP_BITS+MIN_IDLE_BITS)·CLKS_PER_BIT + 1 clocks; the extra clock is the IDLE accept cycle.
- Input stability: tx_data and tx_valid changes outside the accept cycle are ignored. A mid-frame frame is never altered or aborted except by reset.
- tx_ready, busy and Tx are all registered, so there are no combinational paths from input to output.
- Reset mid-frame: Tx returns to 1 immediately. The partial frame is abandoned with no pending byte retained. After release, tx_ready rises only after MIN_IDLE_BITS·CLKS_PER_BIT clocks.

Decomposition:
- Package uart_pkg holds:
  - DATA_BITS=8.
  - State enum {GUARD, IDLE, START, DATA, PARITY, STOP}.
  - Line-level constants LINE_IDLE=1'b1 and START_LVL=1'b0.
  - Parity function even_par(byte).
- Sub-module uart_baud_tick:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, RST_n, clear; output bit_done.
  - Shared later by a receiver rework.
- The FSM and shift register stay in uart_tx_framer.

Test Plan:
- Reset release, defaults: tx_ready=0 for exactly 2 clocks, then 1; Tx=1 throughout.
- Send 0xA5 with defaults: from the cycle after handshake, Tx = 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, then 1,1 guard; busy high 13 clocks.
- Send 0x07 with CLKS_PER_BIT=4: each bit is held 4 clocks.
  - Data LSB-first = 1,1,1,0,0,0,0,0; parity = 1.
  - Frame = 44 clocks; tx_ready stays low until guard ends.
- Back-to-back with tx_valid held and data 0x3C then 0xC3 (defaults): start edges are 14 clocks apart; 0x3C's second byte is not accepted early; both parities = 0.
- RST_n pulsed low during DATA bit 4: Tx=1 asynchronously. After release there are 2 guard clocks, then a fresh 0x55 frame is sent intact.
- Loopback into the receive stage at 125 MHz with defaults: bytes 0x00, 0xFF, 0x81, 0x3C → receiver output equals each byte with check_parity=1.
